// File: rtl/uart_rx_d_if.sv
// Receiver-side bundle: serial input and sample tick in, byte and status out.
interface uart_rx_d_if;
  logic       sample_tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  // Whoever drives the line and the tick (transmitter side / bench).
  modport master (
    output sample_tick, rx,
    input  data, valid, parity_err, frame_err, busy
  );

  // The receiver itself.
  modport slave (
    input  sample_tick, rx,
    output data, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_d.sv
// UART receiver: start, 8 data bits LSB first, even parity, one stop bit.
// Oversampled by an external sample tick; each completed frame (good or bad)
// produces a one-cycle valid pulse with data and error flags.
module uart_rx_d #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_d_if.slave bus
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          perr_q, perr_d;
  logic [7:0]    data_q, data_d;
  logic          perr_out_q, perr_out_d;
  logic          ferr_q, ferr_d;
  logic          valid_q, valid_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: start detect runs every clk, everything else on ticks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only a high-to-low transition counts as a start, so a line held
        // low after a break never retriggers.
        armed_d = armed_q | rx_s_q;
        if (armed_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      S_START: begin
        if (bus.sample_tick) begin
          if (cnt_q == HALF_M1) begin
            cnt_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
              idx_d   = '0;
            end else begin
              state_d = S_IDLE;   // glitch, not a real start bit
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DATA: begin
        if (bus.sample_tick) begin
          if (cnt_q == FULL_M1) begin
            shift_d[idx_q] = rx_s_q;
            cnt_d          = '0;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = S_PARITY;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_PARITY: begin
        if (bus.sample_tick) begin
          if (cnt_q == FULL_M1) begin
            perr_d  = rx_s_q ^ (^shift_q);
            cnt_d   = '0;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_STOP: begin
        if (bus.sample_tick) begin
          if (cnt_q == FULL_M1) begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_d     = ~rx_s_q;
            valid_d    = 1'b1;
            // A good stop leaves IDLE armed for an immediately following
            // start bit; a low stop waits for the line to go high first.
            armed_d    = rx_s_q;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_d.sv
// Bench for uart_rx_d: a frame-level model queues the expected byte/flags
// for every frame sent; a monitor checks outputs on every cycle.
module tb_uart_rx_d;
  localparam int OS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_d_if bus ();

  uart_rx_d #(.OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          n_valid  = 0;
  int          tick_div = 4;
  int          tick_ph  = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_e;
  logic [7:0]  held_data = 8'h00;
  logic        held_perr = 1'b0;
  logic        held_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Sample tick: one clk high every tick_div clks.
  initial begin
    bus.sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_ph++;
      if (tick_ph >= tick_div) tick_ph = 0;
      bus.sample_tick = (tick_ph == 0);
    end
  end

  // Monitor: every valid must match the next queued frame, and the
  // held outputs must match the last frame on every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=valid with data 0x%0h required=no valid", bus.data);
        end else begin
          exp_e     = exp_q.pop_front();
          held_data = exp_e[9:2];
          held_perr = exp_e[1];
          held_ferr = exp_e[0];
          $display("frame %0d data=0x%02h perr=%0b ferr=%0b", n_valid, bus.data, bus.parity_err, bus.frame_err);
        end
      end
      check("mon_data", bus.data, held_data);
      check("mon_parity_err", bus.parity_err, held_perr);
      check("mon_frame_err", bus.frame_err, held_ferr);
    end
  end

  // Global time bound.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL timeout actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (bus.sample_tick) c++;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.rx = b;
    wait_ticks(OS);
  endtask

  // Expected error flags follow directly from what is put on the wire:
  // parity error when the sent parity bit differs from the even parity of
  // the data, frame error when the stop bit is 0.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_q.push_back({d, par ^ (^d), ~stop});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic [7:0] third;

  initial begin
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data", bus.data, 8'h00);
    check("reset_valid", bus.valid, 1'b0);
    check("reset_parity_err", bus.parity_err, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    wait_ticks(2 * OS);

    // Good frame.
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain("good_drain");
    @(negedge clk);
    check("good_data", bus.data, 8'hA5);
    check("good_parity_err", bus.parity_err, 1'b0);
    check("good_frame_err", bus.frame_err, 1'b0);
    check("good_busy_after", bus.busy, 1'b0);

    // Parity error.
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_drain("perr_drain");
    @(negedge clk);
    check("perr_data", bus.data, 8'h3C);
    check("perr_parity_err", bus.parity_err, 1'b1);
    check("perr_frame_err", bus.frame_err, 1'b0);

    // Frame error followed by a long break, then recovery.
    send_frame(8'h81, 1'b0, 1'b0);
    wait_drain("ferr_drain");
    @(negedge clk);
    check("ferr_data", bus.data, 8'h81);
    check("ferr_frame_err", bus.frame_err, 1'b1);
    wait_ticks(40 * OS);
    @(negedge clk);
    check("break_busy", bus.busy, 1'b0);
    check("break_one_valid", n_valid, 3);
    bus.rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h42, 1'b0, 1'b1);
    wait_drain("recover_drain");
    @(negedge clk);
    check("recover_data", bus.data, 8'h42);
    check("recover_parity_err", bus.parity_err, 1'b0);
    check("recover_frame_err", bus.frame_err, 1'b0);

    // Glitch of 4 ticks on an idle line.
    @(negedge clk);
    bus.rx = 1'b0;
    wait_ticks(2);
    @(negedge clk);
    check("glitch_busy_seen", bus.busy, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    bus.rx = 1'b1;
    wait_ticks(5);
    @(negedge clk);
    check("glitch_busy_clear", bus.busy, 1'b0);
    wait_ticks(2 * OS);
    check("glitch_no_valid", n_valid, 4);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_drain("b2b_drain");
    @(negedge clk);
    check("b2b_count", n_valid, 6);
    check("b2b_last_data", bus.data, 8'hFF);

    // Third frame abandoned by reset in the middle of bit 4.
    third = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(third[i]);
    @(negedge clk);
    bus.rx = third[4];
    wait_ticks(OS / 2);
    @(negedge clk);
    check("pre_reset_busy", bus.busy, 1'b1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    held_data = 8'h00;
    held_perr = 1'b0;
    held_ferr = 1'b0;
    #1;
    check("midreset_data", bus.data, 8'h00);
    check("midreset_valid", bus.valid, 1'b0);
    check("midreset_parity_err", bus.parity_err, 1'b0);
    check("midreset_frame_err", bus.frame_err, 1'b0);
    check("midreset_busy", bus.busy, 1'b0);
    for (int i = 5; i < 8; i++) send_bit(third[i]);
    send_bit(^third);
    send_bit(1'b1);
    wait_ticks(OS);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(3 * OS);
    @(negedge clk);
    check("reset_no_valid", n_valid, 6);
    check("after_reset_busy", bus.busy, 1'b0);

    // Serial stream of every byte value, back to back, tick every clk.
    tick_div = 1;
    wait_ticks(2 * OS);
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), ^(8'(b)), 1'b1);
    end
    wait_drain("stream_drain");
    @(negedge clk);
    check("stream_count", n_valid, 262);
    check("stream_last_data", bus.data, 8'hFF);
    check("stream_parity_err", bus.parity_err, 1'b0);
    check("stream_frame_err", bus.frame_err, 1'b0);
    check("stream_busy", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_d.md
# uart_rx_d

UART receiver that consumes the serial line produced by `uart_tx_d` and returns parallel bytes. It sits directly downstream of the transmitter, on the far end of the `tx` wire. Frame format is fixed: start (0), 8 data bits LSB first, even parity bit (XOR of the 8 data bits), stop (1). It uses 16x oversampling from an external sample tick, checks parity and framing, and presents each byte with a one-cycle valid pulse.

## Interface
- `OVERSAMPLE`, default 16: sample ticks per bit period; must be even and ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sample_tick`  input  1  one-`clk` pulse at `OVERSAMPLE` × baud rate.
- `rx`  input  1  serial line, asynchronous to `clk`; idles high.
- `data`  output  8  last received byte; held until the next completed frame.
- `valid`  output  1  one-cycle pulse per completed frame (good or bad).
- `parity_err`  output  1  parity mismatch for the frame; qualified by `valid`.
- `frame_err`  output  1  stop bit sampled 0; qualified by `valid`.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- The `rx` input passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized `rx_s`.
- Internal state:
  - 5-state FSM: IDLE, START, DATA, PARITY, STOP.
  - Tick counter sized to hold `OVERSAMPLE-1`.
  - 3-bit bit index.
  - 8-bit shift register.
  - `armed` flag.
- IDLE:
  - `armed` sets whenever `rx_s` = 1.
  - If `armed` and `rx_s` = 0: go to START, clear the tick counter, clear `armed`.
- START:
  - Each `sample_tick` increments the counter.
  - On the tick where counter = `OVERSAMPLE/2-1` (mid start bit):
    - `rx_s` = 0: go to DATA, clear counter and bit index.
    - `rx_s` = 1: false start; go to IDLE, no output.
- DATA:
  - Each tick increments the counter.
  - On the tick where counter = `OVERSAMPLE-1`: sample `rx_s` into bit `data_idx` (LSB first), clear counter, increment index.
  - After bit 7 is sampled, go to PARITY.
- PARITY:
  - Same mid-bit sampling as DATA.
  - Store `perr = rx_s ^ (^shift)`.
  - Go to STOP.
- STOP:
  - Same mid-bit sampling.
  - On the sample: load `data` ← shift, `parity_err` ← `perr`, `frame_err` ← ~`rx_s`, assert `valid`, go to IDLE.
- Re-arming after a stop: a stop sampled 1 re-arms in IDLE immediately. A frame error (line held low / break) is not re-armed until `rx_s` is seen high, so a held-low line produces exactly one frame.
- The counter advances only on `sample_tick`. No state changes occur between ticks except the IDLE start detect, which is per-`clk`.
- Reset mid-frame: the frame is abandoned. No `valid` pulse follows, and `data` returns to 0.

## Timing
- Reset values:
  - `data` = 0x00, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0.
  - FSM = IDLE, `armed` = 0, counters = 0, shift = 0.
- Input latency: 2 `clk` from an `rx` edge to `rx_s`.
- Start detect: IDLE→START on the first `clk` edge where `rx_s` = 0 and `armed`.
- Sampling points relative to the start detect:
  - Bit n (n = 0…7) is sampled at tick `OVERSAMPLE/2 + (n+1)·OVERSAMPLE`.
  - Parity is sampled at tick `OVERSAMPLE/2 + 9·OVERSAMPLE`.
  - Stop is sampled at tick `OVERSAMPLE/2 + 10·OVERSAMPLE`.
- Output registration:
  - `valid`, `data` and the error flags update on the `clk` edge that consumes the stop-sample tick.
  - `valid` is high for exactly one `clk` cycle, then returns to 0.
  - The error flags hold until the next `valid`.
- `busy` is 1 from the IDLE→START edge through the edge that returns to IDLE.
- Back-to-back frames: a start bit immediately following the stop bit is detected, because IDLE is re-armed during the stop half-bit.
- Ticks arriving on consecutive `clk` cycles are legal. Each tick counts exactly once.

## Test plan
- Good frame: `OVERSAMPLE` = 16, `sample_tick` every 4 `clk`, send 0xA5 with parity 0 and stop 1 → one `valid` pulse, `data` = 0xA5, `parity_err` = 0, `frame_err` = 0, `busy` low afterward.
- Parity error: send 0x3C with parity bit 1 → `valid`, `data` = 0x3C, `parity_err` = 1, `frame_err` = 0.
- Frame error and break:
  - Send 0x81 with stop = 0, then hold the line low for 40 bit times → exactly one `valid`, with `frame_err` = 1.
  - Then release the line high and send 0x42 → `valid`, `data` = 0x42, both error flags 0.
- Glitch rejection: a low pulse of 4 sample ticks on an idle line → no `valid`, FSM back in IDLE, `busy` low within 8 ticks of the pulse start.
- Back-to-back frames plus reset:
  - Send 0x00 then 0xFF with no idle gap → two `valid` pulses, in order.
  - Assert `rst_n` = 0 at bit 4 of a third frame → all outputs are 0 immediately, and no `valid` occurs.
- Loopback: drive `uart_tx_d` with `baud_tick` = every 16th `sample_tick` and connect its `tx` to `rx`. Send the bytes 0x00 through 0xFF → all 256 are received in order with no error flags.
